// File: rtl/crash_monitor.sv
// crash_monitor: per-frame player/enemy contact test and crash/freeze/respawn sequencer.
// Define CRASH_INVULN_EN to add a post-respawn grace period that masks hits.
module crash_monitor #(
   parameter int unsigned NUM_ENEMY     = 3,
   parameter int unsigned HIT_DIST      = 16,
   parameter int unsigned LIVES_INIT    = 3,
   parameter int unsigned CRASH_FRAMES  = 60,
   parameter int unsigned FREEZE_FRAMES = 30,
   parameter int unsigned INVULN_FRAMES = 90
) (
   input  logic                    frame_clk,
   input  logic                    Reset_n,
   input  logic [10:0]             PlayerX,
   input  logic [10:0]             PlayerY,
   input  logic [11*NUM_ENEMY-1:0] EnemyX,
   input  logic [11*NUM_ENEMY-1:0] EnemyY,
   input  logic [NUM_ENEMY-1:0]    enemy_en,
   input  logic                    start,
   output logic                    crash,
   output logic [2:0]              hit_id,
   output logic                    freeze,
   output logic                    respawn,
   output logic [2:0]              lives,
   output logic                    game_over
);

   localparam int unsigned MaxFrames = (CRASH_FRAMES > FREEZE_FRAMES) ? CRASH_FRAMES
                                                                      : FREEZE_FRAMES;
   localparam int unsigned CntW = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;
   localparam logic [CntW-1:0] CrashLast  = CntW'(CRASH_FRAMES - 1);
   localparam logic [CntW-1:0] FreezeLast = CntW'(FREEZE_FRAMES - 1);
   localparam logic [11:0]     HitLim     = 12'(HIT_DIST);
   localparam logic [2:0]      LivesRst   = 3'(LIVES_INIT);

   typedef enum logic [1:0] {StPlay, StCrash, StFreeze, StOver} state_e;

   state_e              state;
   logic [CntW-1:0]     cnt;
   logic [NUM_ENEMY-1:0] hit;
   logic                any_hit;
   logic                hit_live;
   logic [2:0]          hit_idx;

   // Subtraction direction is chosen per enemy so the distance never wraps.
   for (genvar g = 0; g < NUM_ENEMY; g++) begin : g_hit
      logic [10:0] ex, ey, dx, dy;
      assign ex     = EnemyX[11*g +: 11];
      assign ey     = EnemyY[11*g +: 11];
      assign dx     = (PlayerX >= ex) ? (PlayerX - ex) : (ex - PlayerX);
      assign dy     = (PlayerY >= ey) ? (PlayerY - ey) : (ey - PlayerY);
      assign hit[g] = enemy_en[g] & ({1'b0, dx} < HitLim) & ({1'b0, dy} < HitLim);
   end

   assign any_hit = |hit;

   always_comb begin
      hit_idx = 3'd0;
      for (int i = int'(NUM_ENEMY) - 1; i >= 0; i--) begin
         if (hit[i]) hit_idx = 3'(i);
      end
   end

`ifdef CRASH_INVULN_EN
   localparam int unsigned GraceW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
   localparam logic [GraceW-1:0] GraceLoad = GraceW'(INVULN_FRAMES);
   logic [GraceW-1:0] grace;
   assign hit_live = any_hit & (grace == '0);
`else
   logic unused_invuln;
   assign unused_invuln = ^32'(INVULN_FRAMES);
   assign hit_live      = any_hit;
`endif

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= StPlay;
         cnt       <= '0;
         lives     <= LivesRst;
         crash     <= 1'b0;
         hit_id    <= 3'd0;
         freeze    <= 1'b0;
         respawn   <= 1'b0;
         game_over <= 1'b0;
`ifdef CRASH_INVULN_EN
         grace     <= '0;
`endif
      end else begin
         crash   <= 1'b0;
         respawn <= 1'b0;
         unique case (state)
            StPlay: begin
`ifdef CRASH_INVULN_EN
               if (grace != '0) grace <= grace - 1'b1;
`endif
               if (hit_live && (lives != 3'd0)) begin
                  crash  <= 1'b1;
                  hit_id <= hit_idx;
                  lives  <= lives - 3'd1;
                  cnt    <= '0;
                  if (lives == 3'd1) begin
                     state     <= StOver;
                     game_over <= 1'b1;
                     freeze    <= 1'b0;
`ifdef CRASH_INVULN_EN
                     grace     <= '0;
`endif
                  end else begin
                     state  <= StCrash;
                     freeze <= 1'b1;
                  end
               end
            end
            StCrash: begin
               if (cnt == CrashLast) begin
                  state <= StFreeze;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StFreeze: begin
               if (cnt == FreezeLast) begin
                  state   <= StPlay;
                  cnt     <= '0;
                  freeze  <= 1'b0;
                  respawn <= 1'b1;
`ifdef CRASH_INVULN_EN
                  grace   <= GraceLoad;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StOver: begin
               // Restart goes through FREEZE so enemies get a respawn before play.
               if (start) begin
                  state     <= StFreeze;
                  cnt       <= '0;
                  lives     <= LivesRst;
                  freeze    <= 1'b1;
                  game_over <= 1'b0;
               end
            end
            default: begin
               state <= StPlay;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crash_monitor.sv
// Randomized scoreboard bench for crash_monitor against a frame-level behavioural model.
module tb_crash_monitor;

   localparam int N       = 3;
   localparam int HIT     = 16;
   localparam int LINIT   = 3;
   localparam int CFRAMES = 60;
   localparam int FFRAMES = 30;
   localparam int IFRAMES = 90;
   localparam logic [10:0] FAR = 11'd1000;

   logic           frame_clk;
   logic           Reset_n;
   logic [10:0]    PlayerX, PlayerY;
   logic [11*N-1:0] EnemyX, EnemyY;
   logic [N-1:0]   enemy_en;
   logic           start;
   logic           crash, freeze, respawn, game_over;
   logic [2:0]     hit_id, lives;

   crash_monitor #(
      .NUM_ENEMY(N), .HIT_DIST(HIT), .LIVES_INIT(LINIT),
      .CRASH_FRAMES(CFRAMES), .FREEZE_FRAMES(FFRAMES), .INVULN_FRAMES(IFRAMES)
   ) dut (
      .frame_clk(frame_clk), .Reset_n(Reset_n),
      .PlayerX(PlayerX), .PlayerY(PlayerY),
      .EnemyX(EnemyX), .EnemyY(EnemyY), .enemy_en(enemy_en), .start(start),
      .crash(crash), .hit_id(hit_id), .freeze(freeze), .respawn(respawn),
      .lives(lives), .game_over(game_over)
   );

   typedef struct {
      logic       crash;
      logic [2:0] hit_id;
      logic       freeze;
      logic       respawn;
      logic [2:0] lives;
      logic       game_over;
   } exp_t;

   typedef enum {MPlay, MCrash, MFreeze, MOver} mode_t;

   exp_t  exp_q[$];
   int    total = 0;
   int    bad   = 0;

   mode_t m_mode;
   int    m_left, m_lives, m_hid, m_grace;

   initial begin
      frame_clk = 1'b0;
      forever #5 frame_clk = ~frame_clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [32:0] pk(logic [10:0] a, logic [10:0] b, logic [10:0] c);
      return {c, b, a};
   endfunction

   function automatic int adiff(logic [10:0] a, logic [10:0] b);
      int d = int'(a) - int'(b);
      return (d < 0) ? -d : d;
   endfunction

   function automatic void model_reset();
      m_mode = MPlay; m_left = 0; m_lives = LINIT; m_hid = 0; m_grace = 0;
   endfunction

   // One frame of game rules applied to the inputs seen at the clock edge.
   function automatic exp_t model_step(logic [10:0] px, logic [10:0] py, logic [32:0] ex,
                                       logic [32:0] ey, logic [2:0] en, logic st);
      exp_t e;
      bit   found = 0;
      int   id = 0;
      e.crash = 0; e.respawn = 0;
      case (m_mode)
         MPlay: begin
            for (int i = 0; i < N; i++) begin
               if (!found && en[i] && adiff(px, ex[11*i +: 11]) < HIT &&
                   adiff(py, ey[11*i +: 11]) < HIT) begin
                  found = 1; id = i;
               end
            end
`ifdef CRASH_INVULN_EN
            if (m_grace > 0) begin
               found = 0; m_grace--;
            end
`endif
            if (found) begin
               e.crash = 1; m_hid = id; m_lives--;
               if (m_lives == 0) begin
                  m_mode = MOver; m_grace = 0;
               end else begin
                  m_mode = MCrash; m_left = CFRAMES;
               end
            end
         end
         MCrash: begin
            m_left--;
            if (m_left == 0) begin m_mode = MFreeze; m_left = FFRAMES; end
         end
         MFreeze: begin
            m_left--;
            if (m_left == 0) begin m_mode = MPlay; e.respawn = 1; m_grace = IFRAMES; end
         end
         MOver: begin
            if (st) begin m_mode = MFreeze; m_left = FFRAMES; m_lives = LINIT; end
         end
      endcase
      e.hit_id    = 3'(m_hid);
      e.lives     = 3'(m_lives);
      e.freeze    = (m_mode == MCrash) || (m_mode == MFreeze);
      e.game_over = (m_mode == MOver);
      return e;
   endfunction

   task automatic frame(input logic [10:0] px, input logic [10:0] py, input logic [32:0] ex,
                        input logic [32:0] ey, input logic [2:0] en, input logic st);
      @(negedge frame_clk);
      Reset_n = 1'b1;
      PlayerX = px; PlayerY = py; EnemyX = ex; EnemyY = ey; enemy_en = en; start = st;
      exp_q.push_back(model_step(px, py, ex, ey, en, st));
   endtask

   task automatic idle(input int n);
      repeat (n) frame(11'd320, 11'd240, pk(FAR, FAR, FAR), pk(FAR, FAR, FAR), 3'b111, 1'b0);
   endtask

   task automatic check_reset_vals();
      chk("rst_crash", 32'(crash), 0);
      chk("rst_hit_id", 32'(hit_id), 0);
      chk("rst_freeze", 32'(freeze), 0);
      chk("rst_respawn", 32'(respawn), 0);
      chk("rst_lives", 32'(lives), LINIT);
      chk("rst_game_over", 32'(game_over), 0);
   endtask

   // Asynchronous reset between edges; released by the next frame() call.
   task automatic do_reset();
      @(negedge frame_clk);
      #2;
      Reset_n = 1'b0;
      #1;
      check_reset_vals();
      model_reset();
      @(negedge frame_clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge frame_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("crash", 32'(crash), 32'(e.crash));
            chk("hit_id", 32'(hit_id), 32'(e.hit_id));
            chk("freeze", 32'(freeze), 32'(e.freeze));
            chk("respawn", 32'(respawn), 32'(e.respawn));
            chk("lives", 32'(lives), 32'(e.lives));
            chk("game_over", 32'(game_over), 32'(e.game_over));
         end
      end
   end

   initial begin : stim
      logic [10:0] px, py;
      logic [32:0] ex, ey;
      int          off;
      Reset_n = 1'b1;
      PlayerX = 11'd320; PlayerY = 11'd240;
      EnemyX = pk(FAR, FAR, FAR); EnemyY = pk(FAR, FAR, FAR);
      enemy_en = 3'b111; start = 1'b0;
      #2;
      Reset_n = 1'b0;
      #1;
      check_reset_vals();
      model_reset();

      // Enemy 1 overlapping, then full crash/freeze/respawn.
      frame(11'd330, 11'd250, pk(FAR, 11'd320, FAR), pk(FAR, 11'd240, FAR), 3'b111, 1'b0);
      idle(95);
      // X boundary with player below enemy.
      frame(11'd320, 11'd240, pk(11'd336, FAR, FAR), pk(11'd240, FAR, FAR), 3'b111, 1'b0);
      frame(11'd320, 11'd240, pk(11'd335, FAR, FAR), pk(11'd240, FAR, FAR), 3'b111, 1'b0);
      idle(95);
      // X boundary with player above enemy; last life -> OVER.
      frame(11'd336, 11'd240, pk(11'd320, FAR, FAR), pk(11'd240, FAR, FAR), 3'b111, 1'b0);
      frame(11'd335, 11'd240, pk(11'd320, FAR, FAR), pk(11'd240, FAR, FAR), 3'b111, 1'b0);
      repeat (5)
         frame(11'd335, 11'd240, pk(11'd320, FAR, FAR), pk(11'd240, FAR, FAR), 3'b111, 1'b0);
      frame(11'd320, 11'd240, pk(FAR, FAR, FAR), pk(FAR, FAR, FAR), 3'b111, 1'b1);
      idle(35);
      // Y boundaries and enable masking.
      frame(11'd320, 11'd240, pk(11'd320, FAR, FAR), pk(11'd256, FAR, FAR), 3'b111, 1'b1);
      frame(11'd320, 11'd240, pk(11'd320, FAR, FAR), pk(11'd224, FAR, FAR), 3'b111, 1'b0);
      frame(11'd320, 11'd240, pk(11'd320, FAR, FAR), pk(11'd225, FAR, FAR), 3'b110, 1'b0);
      // Enemies 0 and 2 together, overlap held through freeze into the next PLAY frame.
      repeat (93)
         frame(11'd320, 11'd240, pk(11'd320, FAR, 11'd325), pk(11'd240, FAR, 11'd250),
               3'b111, 1'b0);
      // Reset mid-FREEZE.
      idle(70);
      do_reset();
      idle(10);

      // Random play around the player so hits, boundaries and restarts all occur.
      for (int f = 0; f < 3000; f++) begin
         if ($urandom_range(599) == 0) do_reset();
         px = 11'($urandom_range(2047));
         py = 11'($urandom_range(2047));
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(3) == 0) begin
               ex[11*i +: 11] = 11'($urandom_range(2047));
               ey[11*i +: 11] = 11'($urandom_range(2047));
            end else begin
               off = int'($urandom_range(48)) - 24;
               ex[11*i +: 11] = 11'((int'(px) + off) & 2047);
               off = int'($urandom_range(48)) - 24;
               ey[11*i +: 11] = 11'((int'(py) + off) & 2047);
            end
         end
         frame(px, py, ex, ey, 3'($urandom_range(7)), ($urandom_range(7) == 0));
      end

      @(posedge frame_clk);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crash_monitor.md
# crash_monitor

Per-frame player/enemy contact detector and crash sequencer for the Rally-X game core. It sits directly downstream of the `enemy` instances and consumes their `BallX`/`BallY` map coordinates alongside the player's coordinates. It decides when the player has been caught, runs the crash → freeze → respawn sequence and counts lives. Its `freeze` output gates enemy and player motion. Its `respawn` pulse is ORed into the enemy reset.

## Interface
Parameters:
- `NUM_ENEMY`, default 3: number of enemy instances monitored (1–8).
- `HIT_DIST`, default 16: contact radius in pixels per axis; equals the enemy sprite size.
- `LIVES_INIT`, default 3: lives loaded at reset and on restart (1–7).
- `CRASH_FRAMES`, default 60: length of the CRASH state in frames.
- `FREEZE_FRAMES`, default 30: length of the FREEZE state in frames.
- `INVULN_FRAMES`, default 90: post-respawn grace period; used only with `CRASH_INVULN_EN`.

Ports:
- `frame_clk` in 1: frame clock; the only clock.
- `Reset_n` in 1: reset, asynchronous and active-low.
- `PlayerX`, `PlayerY` in 11 each: player map coordinates.
- `EnemyX`, `EnemyY` in `11*NUM_ENEMY` each: packed enemy coordinates; enemy i occupies bits [11i+10:11i].
- `enemy_en` in `NUM_ENEMY`: per-enemy valid; a cleared bit excludes that enemy from hit tests.
- `start` in 1: restart request, honoured only in OVER.
- `crash` out 1: one-frame pulse on the frame the hit is registered.
- `hit_id` out 3: index of the lowest-numbered enemy hit, latched at `crash`.
- `freeze` out 1: high in CRASH and FREEZE; movers hold position.
- `respawn` out 1: one-frame pulse on leaving FREEZE.
- `lives` out 3: remaining lives.
- `game_over` out 1: high in OVER.

## Operation
- Hit test, combinational and parallel for all i: `dx = |PlayerX − EnemyXi|` and `dy = |PlayerY − EnemyYi|`.
  - Both differences are computed as 11-bit unsigned with operands swapped, so they never wrap.
  - `hit_i = enemy_en[i] & (dx < HIT_DIST) & (dy < HIT_DIST)`.
  - `any_hit` is the OR of all `hit_i`. `hit_id` takes the priority-encoded lowest index.
- States are PLAY, CRASH, FREEZE, OVER.
- PLAY, on `any_hit`:
  - Pulse `crash`, latch `hit_id`, decrement `lives`.
  - If the old `lives` == 1, go to OVER; otherwise go to CRASH.
- CRASH:
  - Hits are ignored.
  - The frame counter runs from 0 to `CRASH_FRAMES−1`, then the FSM goes to FREEZE with the counter cleared.
- FREEZE:
  - Same counting, up to `FREEZE_FRAMES−1`.
  - On exit, pulse `respawn` and go to PLAY.
- OVER:
  - `lives` = 0, `freeze` = 0, hits are ignored.
  - On `start`, reload `lives = LIVES_INIT` and go to FREEZE with the counter cleared, so enemies respawn before play resumes.
- `lives` never underflows. A decrement happens only in PLAY with `lives` ≥ 1.
- Simultaneous hits by several enemies in one frame cost exactly one life. `hit_id` reports the lowest index.

## Timing
- All outputs are registered on `frame_clk`. The hit seen at frame-edge N appears on `crash`/`freeze` after edge N, i.e. one frame latency.
- `freeze` rises in the same cycle as `crash`.
- `respawn` is high for exactly one frame, the cycle in which the state becomes PLAY.
- Hits in that first PLAY frame count; enemies are still at their pre-reset positions in that frame.
  - Without `CRASH_INVULN_EN`, integration must guarantee that enemies are already reset.
- Reset values, applied asynchronously while `Reset_n` = 0:
  - state = PLAY, counter = 0, `lives` = `LIVES_INIT`.
  - `crash` = 0, `hit_id` = 0, `freeze` = 0, `respawn` = 0, `game_over` = 0.
- Reset asserted mid-CRASH/FREEZE abandons the sequence immediately. No `respawn` pulse is generated.
- `start` asserted outside OVER is ignored.
- The counter is wide enough for the maximum of the frame parameters. It is cleared on every state change.

## Configuration
- `CRASH_INVULN_EN` defined:
  - Entering PLAY from FREEZE loads a grace counter with `INVULN_FRAMES`.
  - While the grace counter is nonzero, `any_hit` is masked. The counter decrements once per frame in PLAY.
  - Reset and entry to OVER clear the grace counter.
- Not defined:
  - No grace counter exists and hits are honoured from the first PLAY frame.
  - `INVULN_FRAMES` is unused.

## Test plan
- Reset, then enemy 1 at (320,240) with player at (330,250), all enables 1 → next frame: `crash` = 1, `hit_id` = 1, `lives` = 2, `freeze` = 1.
- Player (320,240), enemy 0 at (336,240), i.e. dx = 16 → no hit. Move enemy 0 to (335,240) → hit. Repeat with the player greater than the enemy to check the operand swap.
- Enemies 0 and 2 both overlapping the player in the same frame → one `crash`, `hit_id` = 0, `lives` drops by exactly 1.
- After a crash, count frames → `freeze` high for exactly 90 frames, `respawn` a single pulse on frame 91, state PLAY.
- Three crashes from `LIVES_INIT` = 3 → `game_over` = 1, `lives` = 0. Further hits do nothing. `start` → `lives` = 3, 30 frames frozen, then `respawn`.
- With `CRASH_INVULN_EN`: overlap held continuously after `respawn` → no `crash` for 90 frames, `crash` on frame 91. Without the macro → `crash` on the first PLAY frame.
- `Reset_n` pulsed low mid-FREEZE → all outputs return to reset values immediately, no `respawn`.
